// File: rtl/ex_stage_pkg.sv
// Shared widths, stall encoding, ALU/operand-select bit positions and the EX register layout.
package ex_stage_pkg;

    localparam int STALL_BUS    = 6;
    localparam int ID_TO_EX_WD  = 159;
    localparam int EX_TO_MEM_WD = 76;
    localparam int EX_TO_RF_WD  = 38;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;
    localparam int   STALL_ID = 2;
    localparam int   STALL_EX = 3;

    // alu_op bit positions, MSB first: {add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui}
    localparam int ALU_ADD  = 11;
    localparam int ALU_SUB  = 10;
    localparam int ALU_SLT  = 9;
    localparam int ALU_SLTU = 8;
    localparam int ALU_AND  = 7;
    localparam int ALU_NOR  = 6;
    localparam int ALU_OR   = 5;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLL  = 3;
    localparam int ALU_SRL  = 2;
    localparam int ALU_SRA  = 1;
    localparam int ALU_LUI  = 0;

    localparam int SRC1_RS    = 0;
    localparam int SRC1_PC    = 1;
    localparam int SRC1_SA    = 2;
    localparam int SRC2_RT    = 0;
    localparam int SRC2_SIMM  = 1;
    localparam int SRC2_EIGHT = 2;
    localparam int SRC2_ZIMM  = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] alu_op;
        logic [2:0]  src1_sel;
        logic [3:0]  src2_sel;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        sel_rf_res;
        logic [31:0] rdata1;
        logic [31:0] rdata2;
    } id_ex_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU; alu_op is one-hot and an all-zero op yields zero.
module alu
    import ex_stage_pkg::*;
(
    input  logic [11:0] alu_op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic [31:0] result
);

    logic [31:0] sum;
    logic [31:0] diff;
    logic [31:0] slt_res;
    logic [31:0] sltu_res;
    logic [31:0] sra_res;
    logic [4:0]  sh;

    assign sh       = src1[4:0];
    assign sum      = src1 + src2;
    assign diff     = src1 - src2;
    assign slt_res  = {31'b0, $signed(src1) < $signed(src2)};
    assign sltu_res = {31'b0, src1 < src2};
    assign sra_res  = $unsigned($signed(src2) >>> sh);

    always_comb begin
        result = '0;
        result |= {32{alu_op[ALU_ADD]}}  & sum;
        result |= {32{alu_op[ALU_SUB]}}  & diff;
        result |= {32{alu_op[ALU_SLT]}}  & slt_res;
        result |= {32{alu_op[ALU_SLTU]}} & sltu_res;
        result |= {32{alu_op[ALU_AND]}}  & (src1 & src2);
        result |= {32{alu_op[ALU_NOR]}}  & ~(src1 | src2);
        result |= {32{alu_op[ALU_OR]}}   & (src1 | src2);
        result |= {32{alu_op[ALU_XOR]}}  & (src1 ^ src2);
        result |= {32{alu_op[ALU_SLL]}}  & (src2 << sh);
        result |= {32{alu_op[ALU_SRL]}}  & (src2 >> sh);
        result |= {32{alu_op[ALU_SRA]}}  & sra_res;
        result |= {32{alu_op[ALU_LUI]}}  & {src2[15:0], 16'b0};
    end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: registers the decoded instruction, runs the ALU and issues lw/sw to the data SRAM.
// The issued flag keeps a held memory instruction from requesting the SRAM more than once.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_BUS-1:0]    stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
    output logic                    ex_is_load,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata
);

    id_ex_t      id_in;
    id_ex_t      ex_reg;
    logic        issued;
    logic        load_new;
    logic        valid;
    logic        sram_go;
    logic        fwd_we;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] ex_result;
    logic        unused_ok;

    assign id_in = id_to_ex_bus;

    // The register holds only when both ID and EX are stopped; any other pattern loads something.
    assign load_new = (stall[STALL_ID] == NO_STOP) || (stall[STALL_EX] == NO_STOP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_reg <= '0;
        end else if (stall[STALL_ID] == STOP && stall[STALL_EX] == NO_STOP) begin
            ex_reg <= '0;
        end else if (stall[STALL_ID] == NO_STOP) begin
            ex_reg <= id_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issued <= 1'b0;
        end else if (load_new) begin
            issued <= 1'b0;
        end else if (data_sram_en && stall[STALL_EX] == STOP) begin
            issued <= 1'b1;
        end
    end

    always_comb begin
        src1 = '0;
        src1 |= {32{ex_reg.src1_sel[SRC1_RS]}} & ex_reg.rdata1;
        src1 |= {32{ex_reg.src1_sel[SRC1_PC]}} & ex_reg.pc;
        src1 |= {32{ex_reg.src1_sel[SRC1_SA]}} & {27'b0, ex_reg.inst[10:6]};
    end

    always_comb begin
        src2 = '0;
        src2 |= {32{ex_reg.src2_sel[SRC2_RT]}}    & ex_reg.rdata2;
        src2 |= {32{ex_reg.src2_sel[SRC2_SIMM]}}  & sext16(ex_reg.inst[15:0]);
        src2 |= {32{ex_reg.src2_sel[SRC2_EIGHT]}} & 32'd8;
        src2 |= {32{ex_reg.src2_sel[SRC2_ZIMM]}}  & {16'b0, ex_reg.inst[15:0]};
    end

    alu u_alu (
        .alu_op (ex_reg.alu_op),
        .src1   (src1),
        .src2   (src2),
        .result (ex_result)
    );

    assign valid   = |ex_reg;
    assign sram_go = valid && ex_reg.ram_en && !issued;
    // Load data arrives from the memory stage, so EX never forwards a load's address.
    assign fwd_we  = valid && ex_reg.rf_we && !ex_reg.sel_rf_res;

    assign data_sram_en    = sram_go;
    assign data_sram_wen   = {4{sram_go}} & ex_reg.ram_wen;
    assign data_sram_addr  = ex_result;
    assign data_sram_wdata = ex_reg.rdata2;
    assign ex_is_load      = valid && ex_reg.sel_rf_res;

    assign ex_to_rf_bus  = {fwd_we, ex_reg.rf_waddr, ex_result};
    assign ex_to_mem_bus = {ex_reg.pc, ex_reg.ram_en, ex_reg.ram_wen, ex_reg.sel_rf_res,
                            ex_reg.rf_we, ex_reg.rf_waddr, ex_result};

    assign unused_ok = ^{stall[5:4], stall[1:0], ex_reg.inst[31:16]};

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage MIPS pipeline: the consumer of the decode-stage `id_to_ex_bus`. It registers the decoded instruction, evaluates the ALU, and issues the data-SRAM request for `lw`/`sw`. It forwards its result back to decode on `ex_to_rf_bus` and hands the instruction to the memory stage on `ex_to_mem_bus`. A one-bit issue guard ensures a stalled memory instruction accesses the data SRAM exactly once.

## Interface
- No parameters. Widths come from `lib/defines.vh`: `StallBus`=6, `ID_TO_EX_WD`=159, and new `EX_TO_MEM_WD`=76.
- `clk`  input  1  pipeline clock.
- `rst`  input  1  reset, asynchronous and active-low: clears state immediately while low.
- `stall`  input  `StallBus`  per-stage stall vector. Bit 2 is ID, bit 3 is EX; `Stop`=1, `NoStop`=0.
- `id_to_ex_bus`  input  159  fields:
  - pc[158:127], inst[126:95]
  - alu_op[94:83] = {add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui}
  - src1_sel[82:80] = {sa,pc,rs}; src2_sel[79:76] = {zimm,8,simm,rt}
  - ram_en[75], ram_wen[74:71], rf_we[70], rf_waddr[69:65], sel_rf_res[64]
  - rdata1[63:32], rdata2[31:0]
- `ex_to_mem_bus`  output  76  {pc[75:44], ram_en[43], ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}.
- `ex_to_rf_bus`  output  38  {fwd_we, rf_waddr, ex_result}. `fwd_we` = valid & rf_we & ~sel_rf_res.
- `ex_is_load`  output  1  EX holds a load; decode uses this for load-use stall.
- `data_sram_en`  output  1  data-SRAM access request.
- `data_sram_wen`  output  4  byte write enables.
- `data_sram_addr`  output  32  = ex_result.
- `data_sram_wdata`  output  32  = rdata2.

## Operation
- EX register update, in priority order:
  - `rst` low: clear to 0.
  - stall[2]=Stop and stall[3]=NoStop: load all-zero (bubble).
  - stall[2]=NoStop: capture `id_to_ex_bus`.
  - Otherwise: hold.
- Valid: a zero register is a bubble. Every enable output is 0 for a bubble.
- Source 1 selection (one-hot):
  - rs → rdata1
  - pc → pc
  - sa → {27'b0, inst[10:6]}
  - No bit set → 0.
- Source 2 selection (one-hot):
  - rt → rdata2
  - simm → sign-extended inst[15:0]
  - 8 → 32'd8
  - zimm → zero-extended inst[15:0]
  - No bit set → 0.
- ALU result, selected one-hot by alu_op:
  - add / sub: mod 2^32, no overflow trap.
  - slt: signed compare, result {31'b0, lt}. sltu: unsigned compare.
  - and, or, xor, nor: bitwise.
  - sll: src2 << src1[4:0]. srl: logical right shift. sra: arithmetic right shift.
  - lui: {src2[15:0], 16'b0}.
  - alu_op = 0 → result 0.
- Data-SRAM request:
  - `data_sram_en` = ram_en & ~issued.
  - `data_sram_wen` = ram_wen gated by the same condition.
- Issue guard `issued`:
  - Set at a clock edge when `data_sram_en`=1 and stall[3]=Stop.
  - Cleared whenever the EX register loads a new instruction or a bubble, and on reset.
- `ex_is_load` = sel_rf_res. Load data is never forwarded from EX.

## Timing
- Latency: `id_to_ex_bus` is captured at edge N. All outputs are valid combinationally after edge N, within the same cycle.
- `data_sram_en` is high for exactly one cycle per memory instruction, regardless of how long EX is held.
- SRAM read data returns at edge N+1; the memory stage consumes it.
- Reset outputs: every output is 0 (bubble) while `rst` is low. `issued`=0.
- Simultaneous issue and capture (stall[3]=NoStop): `issued` stays 0 and the next instruction may issue in the following cycle.
- Reset asserted mid-hold: the instruction is dropped and no request is re-issued.

## Structure
- `defines.vh` holds:
  - `EX_TO_MEM_WD`.
  - alu_op bit-position constants, shared with decode.
  - src1/src2 select bit-position constants.
- Sub-module `alu` is purely combinational: inputs alu_op[11:0], src1, src2; output result[31:0].
- `ex_stage` contains only the EX register, the `issued` flag, the operand muxes and bus packing.

## Test plan
- `addiu` with rdata1=0x7FFFFFFF, simm=1, stall=0 → next cycle ex_result=0x80000000; `ex_to_rf_bus`={1, rt, 0x80000000}.
- `sw` with rdata1=0x100, simm=0xFFFC, rdata2=0xDEADBEEF → addr=0xFC, wdata=0xDEADBEEF, wen=4'hF, en=1.
- Same `sw` held 3 cycles with stall=6'b001111 → `data_sram_en` high in the first cycle only; `ex_to_mem_bus` is unchanged throughout.
- stall=6'b000111 → next cycle bubble: `ex_to_mem_bus`=0, `data_sram_en`=0, fwd_we=0.
- `lw` → ex_is_load=1, fwd_we=0, en=1, wen=0.
- `jal` at pc=0x1000 → ex_result=0x1008. `sra` with rt=0x80000000, sa=4 → 0xF8000000. Assert `rst` low mid-cycle → all outputs 0 immediately.
